// File: rtl/alu_issue_stage.sv
// Purpose : command FIFO plus issue FSM in front of the 4-bit combinational ALU; captures and returns its 8-bit result.
// Latency : push at edge N -> operands issued at N+1 -> oRES_VALID high after N+2; one result per 2 cycles sustained.
// Backpr. : oRES_VALID/oRESULT held until iRES_READY; oCMD_READY drops only when FIFO_DEPTH entries are buffered.
//
// Ports:
//   iCLK, iRSTn                          clock, asynchronous active-low reset
//   iCMD_VALID/oCMD_READY, iCMD_A/B/INST command push handshake and payload
//   oALU_A/B/INST, iALU_RESULT           registered operands to the ALU, combinational result back
//   oRES_VALID/iRES_READY, oRESULT,
//   oRES_INST, oDZ                       result return handshake and payload
//   oBUSY                                FIFO non-empty or a command in flight
// Build option: define ALU_DIVZERO_CHK_EN to force 8'hFF and raise oDZ on divide/modulo by zero.

module alu_issue_stage #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iCMD_VALID,
    output logic       oCMD_READY,
    input  logic [3:0] iCMD_A,
    input  logic [3:0] iCMD_B,
    input  logic [3:0] iCMD_INST,
    output logic [3:0] oALU_A,
    output logic [3:0] oALU_B,
    output logic [3:0] oALU_INST,
    input  logic [7:0] iALU_RESULT,
    output logic       oRES_VALID,
    input  logic       iRES_READY,
    output logic [7:0] oRESULT,
    output logic [3:0] oRES_INST,
    output logic       oDZ,
    output logic       oBUSY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] inst;
    } cmd_t;

    cmd_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_state;
    logic [3:0]    r_alu_a;
    logic [3:0]    r_alu_b;
    logic [3:0]    r_alu_inst;
    logic [7:0]    r_result;
    logic [3:0]    r_res_inst;
    logic          r_res_vld;
    logic          r_dz;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_dz;
    logic [7:0]    w_res;
    cmd_t          w_head;

    assign w_nonempty = (r_cnt != '0);
    assign oCMD_READY = (r_cnt != CW'(FIFO_DEPTH));
    assign w_push     = iCMD_VALID & oCMD_READY;
    // Pop decision uses only the registered count, so a push into an empty
    // FIFO cannot be popped in the same cycle.
    assign w_pop      = w_nonempty &
                        ((r_state == S_IDLE) | ((r_state == S_HOLD) & iRES_READY));
    assign w_head     = r_mem[r_rptr];

`ifdef ALU_DIVZERO_CHK_EN
    // Opcodes 3 (DIV) and 4 (MOD) with a zero divisor return a saturated value.
    assign w_dz  = ((r_alu_inst == 4'h3) || (r_alu_inst == 4'h4)) && (r_alu_b == 4'h0);
    assign w_res = w_dz ? 8'hFF : iALU_RESULT;
`else
    assign w_dz  = 1'b0;
    assign w_res = iALU_RESULT;
`endif

    // Storage array carries no reset: entries are only read after being written,
    // and the pointer reset already discards stale contents.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{a: iCMD_A, b: iCMD_B, inst: iCMD_INST};
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state    <= S_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_inst <= '0;
            r_result   <= '0;
            r_res_inst <= '0;
            r_res_vld  <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a    <= w_head.a;
                r_alu_b    <= w_head.b;
                r_alu_inst <= w_head.inst;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result   <= w_res;
                    r_res_inst <= r_alu_inst;
                    r_dz       <= w_dz;
                    r_res_vld  <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (iRES_READY) begin
                        r_res_vld <= 1'b0;
                        r_state   <= w_pop ? S_EXEC : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oALU_A     = r_alu_a;
    assign oALU_B     = r_alu_b;
    assign oALU_INST  = r_alu_inst;
    assign oRESULT    = r_result;
    assign oRES_INST  = r_res_inst;
    assign oRES_VALID = r_res_vld;
    assign oDZ        = r_dz;
    assign oBUSY      = w_nonempty | (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose : directed self-checking bench for alu_issue_stage with a behavioural ALU stand-in.
// Latency : expectations follow push at N -> issue N+1 -> result valid after N+2.
// Backpr. : exercises held results under iRES_READY low and a full command FIFO.

module tb_alu_issue_stage;

    logic       iCLK = 1'b0;
    logic       iRSTn;
    logic       iCMD_VALID;
    logic       oCMD_READY;
    logic [3:0] iCMD_A;
    logic [3:0] iCMD_B;
    logic [3:0] iCMD_INST;
    logic [3:0] oALU_A;
    logic [3:0] oALU_B;
    logic [3:0] oALU_INST;
    logic [7:0] iALU_RESULT;
    logic       oRES_VALID;
    logic       iRES_READY;
    logic [7:0] oRESULT;
    logic [3:0] oRES_INST;
    logic       oDZ;
    logic       oBUSY;

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    alu_issue_stage #(.FIFO_DEPTH(4)) dut (
        .iCLK        (iCLK),
        .iRSTn       (iRSTn),
        .iCMD_VALID  (iCMD_VALID),
        .oCMD_READY  (oCMD_READY),
        .iCMD_A      (iCMD_A),
        .iCMD_B      (iCMD_B),
        .iCMD_INST   (iCMD_INST),
        .oALU_A      (oALU_A),
        .oALU_B      (oALU_B),
        .oALU_INST   (oALU_INST),
        .iALU_RESULT (iALU_RESULT),
        .oRES_VALID  (oRES_VALID),
        .iRES_READY  (iRES_READY),
        .oRESULT     (oRESULT),
        .oRES_INST   (oRES_INST),
        .oDZ         (oDZ),
        .oBUSY       (oBUSY)
    );

    // Stand-in for the downstream ALU; a zero divisor yields an arbitrary 8'h5A.
    always_comb begin
        iALU_RESULT = 8'h00;
        case (oALU_INST)
            4'h0: iALU_RESULT = {4'h0, oALU_A} + {4'h0, oALU_B};
            4'h1: iALU_RESULT = {4'h0, oALU_A} - {4'h0, oALU_B};
            4'h2: iALU_RESULT = {4'h0, oALU_A} * {4'h0, oALU_B};
            4'h3: iALU_RESULT = (oALU_B == 4'h0) ? 8'h5A : {4'h0, oALU_A / oALU_B};
            4'h4: iALU_RESULT = (oALU_B == 4'h0) ? 8'h5A : {4'h0, oALU_A % oALU_B};
            4'hF: iALU_RESULT = {4'h0, oALU_A} << oALU_B;
            default: iALU_RESULT = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        iCMD_VALID = v;
        iCMD_A     = a;
        iCMD_B     = b;
        iCMD_INST  = op;
    endtask

    // Waits (bounded) for a result, checks it, then advances one edge so a
    // high iRES_READY consumes it.
    task automatic expect_result(input string tag, input logic [7:0] er, input logic [3:0] ei, input logic ed);
        int n = 0;
        while (!oRES_VALID && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 32'(oRES_VALID), 32'd1);
        check({tag, "_res"}, 32'(oRESULT), 32'(er));
        check({tag, "_inst"}, 32'(oRES_INST), 32'(ei));
        check({tag, "_dz"}, 32'(oDZ), 32'(ed));
        tick();
    endtask

    initial begin
        logic any_vld;
        logic [7:0] dz_res;
        logic dz_flag;

        iRSTn      = 1'b1;
        iRES_READY = 1'b0;
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        #1 iRSTn = 1'b0;
        #2;
        check("rst_vld",    32'(oRES_VALID), 32'd0);
        check("rst_busy",   32'(oBUSY),      32'd0);
        check("rst_alu_a",  32'(oALU_A),     32'd0);
        check("rst_alu_b",  32'(oALU_B),     32'd0);
        check("rst_alu_op", 32'(oALU_INST),  32'd0);
        check("rst_result", 32'(oRESULT),    32'd0);
        check("rst_resop",  32'(oRES_INST),  32'd0);
        check("rst_dz",     32'(oDZ),        32'd0);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK) iRSTn = 1'b1;
        tick();
        check("rst_cmd_rdy", 32'(oCMD_READY), 32'd1);

        // Single ADD: 7 + 9 = 0x10, valid exactly two edges after the push edge.
        iRES_READY = 1'b1;
        drive_cmd(1'b1, 4'h7, 4'h9, 4'h0);
        tick();
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        check("add_n_vld",   32'(oRES_VALID), 32'd0);
        check("add_n_busy",  32'(oBUSY),      32'd1);
        tick();
        check("add_n1_vld",  32'(oRES_VALID), 32'd0);
        check("add_n1_a",    32'(oALU_A),     32'h7);
        check("add_n1_b",    32'(oALU_B),     32'h9);
        tick();
        check("add_n2_vld",  32'(oRES_VALID), 32'd1);
        check("add_n2_res",  32'(oRESULT),    32'h10);
        check("add_n2_inst", 32'(oRES_INST),  32'h0);
        tick();
        check("add_done_vld",  32'(oRES_VALID), 32'd0);
        check("add_done_busy", 32'(oBUSY),      32'd0);

        // MUL then LSHFT back to back: F*F = 0xE1, 9<<1 = 0x12, two cycles apart.
        drive_cmd(1'b1, 4'hF, 4'hF, 4'h2);
        tick();
        drive_cmd(1'b1, 4'h9, 4'h1, 4'hF);
        tick();
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        check("mul_vld",  32'(oRES_VALID), 32'd1);
        check("mul_res",  32'(oRESULT),    32'hE1);
        check("mul_inst", 32'(oRES_INST),  32'h2);
        tick();
        check("mul_gap_vld", 32'(oRES_VALID), 32'd0);
        tick();
        check("lsh_vld",  32'(oRES_VALID), 32'd1);
        check("lsh_res",  32'(oRESULT),    32'h12);
        check("lsh_inst", 32'(oRES_INST),  32'hF);
        tick();
        tick();
        check("lsh_idle_busy", 32'(oBUSY), 32'd0);

        // Back-pressure: five ADDs (A=i+1, B=i) with the consumer stalled.
        iRES_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_rdy", 32'(oCMD_READY), 32'd1);
            drive_cmd(1'b1, 4'(i + 1), 4'(i), 4'h0);
            tick();
        end
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        check("bp_full_rdy", 32'(oCMD_READY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_vld", 32'(oRES_VALID), 32'd1);
            check("bp_hold_res", 32'(oRESULT),    32'h01);
            tick();
        end
        check("bp_still_full", 32'(oCMD_READY), 32'd0);
        iRES_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_result("bp_drain", 8'(2 * i + 1), 4'h0, 1'b0);
        end
        any_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_vld = any_vld | oRES_VALID;
            tick();
        end
        check("bp_no_dup", 32'(any_vld), 32'd0);
        check("bp_busy",   32'(oBUSY),   32'd0);

        // Simultaneous push/pop at count 3, write pointer wrapping past entry 3.
        iRES_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b1, 4'(i + 3), 4'h2, 4'h2);
            tick();
        end
        check("pp_hold_vld", 32'(oRES_VALID), 32'd1);
        check("pp_hold_res", 32'(oRESULT),    32'h06);
        check("pp_cnt3_rdy", 32'(oCMD_READY), 32'd1);
        iRES_READY = 1'b1;
        drive_cmd(1'b1, 4'h7, 4'h2, 4'h2);
        tick();
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        check("pp_cnt_rdy",  32'(oCMD_READY), 32'd1);
        check("pp_issue_a",  32'(oALU_A),     32'h4);
        check("pp_gap_vld",  32'(oRES_VALID), 32'd0);
        for (int i = 1; i < 5; i++) begin
            expect_result("pp_drain", 8'(2 * (i + 3)), 4'h2, 1'b0);
        end
        tick();
        check("pp_busy", 32'(oBUSY), 32'd0);

        // Divide by zero, then a legal divide 8/2 = 4.
`ifdef ALU_DIVZERO_CHK_EN
        dz_res  = 8'hFF;
        dz_flag = 1'b1;
`else
        dz_res  = 8'h5A;
        dz_flag = 1'b0;
`endif
        drive_cmd(1'b1, 4'h8, 4'h0, 4'h3);
        tick();
        drive_cmd(1'b1, 4'h8, 4'h2, 4'h3);
        tick();
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        expect_result("div0", dz_res, 4'h3, dz_flag);
        expect_result("div2", 8'h04,  4'h3, 1'b0);
        tick();

        // Reset while holding a result with two commands queued.
        iRES_READY = 1'b0;
        drive_cmd(1'b1, 4'h1, 4'h2, 4'h0);
        tick();
        drive_cmd(1'b1, 4'h3, 4'h4, 4'h0);
        tick();
        drive_cmd(1'b1, 4'h5, 4'h6, 4'h0);
        tick();
        drive_cmd(1'b0, 4'h0, 4'h0, 4'h0);
        check("mr_pre_vld",  32'(oRES_VALID), 32'd1);
        check("mr_pre_busy", 32'(oBUSY),      32'd1);
        #2 iRSTn = 1'b0;
        #1;
        check("mr_vld",    32'(oRES_VALID), 32'd0);
        check("mr_result", 32'(oRESULT),    32'd0);
        check("mr_resop",  32'(oRES_INST),  32'd0);
        check("mr_alu_a",  32'(oALU_A),     32'd0);
        check("mr_alu_b",  32'(oALU_B),     32'd0);
        check("mr_alu_op", 32'(oALU_INST),  32'd0);
        check("mr_busy",   32'(oBUSY),      32'd0);
        check("mr_dz",     32'(oDZ),        32'd0);
        @(negedge iCLK) iRSTn = 1'b1;
        iRES_READY = 1'b1;
        tick();
        check("mr_cmd_rdy", 32'(oCMD_READY), 32'd1);
        any_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_vld = any_vld | oRES_VALID | oBUSY;
            tick();
        end
        check("mr_no_stale", 32'(any_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command front-end that sits directly upstream of the 4-bit combinational ALU. It buffers incoming operation commands (A, B, INST) in a 4-entry FIFO and presents one command at a time on registered operand/opcode outputs that drive the ALU inputs. It captures the ALU's 8-bit result one cycle later and returns it to the consumer over a valid/ready handshake. Optionally, it detects divide/modulo by zero.

## Interface
Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)

Ports:
- iCLK  in  1  clock, all state on rising edge
- iRSTn  in  1  asynchronous active-low reset
- iCMD_VALID  in  1  command valid
- oCMD_READY  out  1  FIFO can accept (count < FIFO_DEPTH)
- iCMD_A  in  4  operand A
- iCMD_B  in  4  operand B
- iCMD_INST  in  4  opcode (ALU encoding 4'h0–4'hF)
- oALU_A  out  4  registered operand A to ALU iA
- oALU_B  out  4  registered operand B to ALU iB
- oALU_INST  out  4  registered opcode to ALU iINST
- iALU_RESULT  in  8  ALU oRESULT (combinational return)
- oRES_VALID  out  1  result valid
- iRES_READY  in  1  consumer accepts result
- oRESULT  out  8  captured result
- oRES_INST  out  4  opcode that produced oRESULT
- oDZ  out  1  divide/mod-by-zero flag, qualified by oRES_VALID
- oBUSY  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Push: on iCMD_VALID & oCMD_READY, {A,B,INST} is written at the write pointer, and the pointer increments modulo FIFO_DEPTH.
- Pop: only the FSM pops, and only when the FIFO is non-empty. The popped entry loads oALU_A/B/INST.
- Push and pop in the same cycle: count is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle.
- The count is (FIFO_DEPTH+1) values wide. Pointers wrap silently.
- FSM states:
  - IDLE: if FIFO non-empty → pop, go EXEC.
  - EXEC: capture iALU_RESULT → oRESULT, oALU_INST → oRES_INST, set oRES_VALID, go HOLD.
  - HOLD: oRESULT, oRES_INST and oDZ are held stable while oRES_VALID & !iRES_READY. On iRES_READY: clear oRES_VALID. If FIFO non-empty, pop and go EXEC, else go IDLE.
- oALU_* keep the last issued command until the next pop. They are never X after reset.
- No result is ever dropped or duplicated. Results return in command order.

## Timing
- Reset (async assert, sync release) values:
  - FIFO pointers/count = 0
  - FSM = IDLE
  - oALU_A = oALU_B = oALU_INST = 0
  - oRESULT = 0, oRES_INST = 0
  - oRES_VALID = 0, oDZ = 0, oBUSY = 0
  - oCMD_READY = 1 once reset is released
- Latency from push into an empty, idle block:
  - push at edge N
  - pop/issue at N+1
  - oRES_VALID high after N+2
- Sustained throughput with iRES_READY held high: one result per 2 cycles.
- oCMD_READY is a registered-state function (count < FIFO_DEPTH). It has no combinational path from iRES_READY.
- Reset asserted mid-operation: FIFO contents and in-flight results are discarded immediately, and all outputs go to their reset values.

## Configuration
- ALU_DIVZERO_CHK_EN defined:
  - In EXEC, if oALU_INST is 4'h3 or 4'h4 and oALU_B == 0, oRESULT is forced to 8'hFF and oDZ = 1.
  - Otherwise oDZ = 0 and the ALU value passes through.
- Undefined:
  - iALU_RESULT is captured unconditionally.
  - oDZ is tied to 0.

## Test plan
- Single ADD: push A=4'h7, B=4'h9, INST=4'h0 with iRES_READY=1 → oRES_VALID exactly 2 cycles after the push edge, oRESULT=8'h10, oRES_INST=4'h0.
- Back-pressure: push 5 commands with iRES_READY=0 → oCMD_READY deasserts after 4 are buffered plus 1 is held in HOLD. Then raise iRES_READY → 5 results in order, with no loss or duplication.
- Simultaneous push/pop at count=3: count stays 3, wrap-around of the write pointer past entry 3 is verified, and data stays intact.
- Divide by zero: push A=4'h8, B=0, INST=4'h3 → with ALU_DIVZERO_CHK_EN: oRESULT=8'hFF, oDZ=1. Without it: oDZ=0 and oRESULT=iALU_RESULT.
- Reset mid-stream: assert iRSTn low while in HOLD with 2 entries queued → all outputs return to reset values asynchronously. After release, oBUSY=0 and oCMD_READY=1, and no stale result appears.
- MUL/LSHFT: A=4'hF, B=4'hF, INST=4'h2 → 8'hE1. Then A=4'h9, INST=4'hF → 8'h12 (ALU zero-extends iA before shifting). Results are returned back-to-back, 2 cycles apart.
